// File: rtl/arbitro_bus16_2x1_if.sv
// Bus bundle shared between the two requesters, the shared resource and the
// arbiter. "master" is the requester/resource side, "slave" is the arbiter.
interface arbitro_bus16_2x1_if #(
  parameter int ANCHO = 16
);
  logic             Solicitud0;
  logic             Solicitud1;
  logic [ANCHO-1:0] Dato0;
  logic [ANCHO-1:0] Dato1;
  logic             Listo;
  logic             Concesion0;
  logic             Concesion1;
  logic             Selector;
  logic [ANCHO-1:0] Salida;
  logic             Valido;
  logic             Hecho0;
  logic             Hecho1;
  logic             ErrorEspera;

  modport master (
    output Solicitud0, Solicitud1, Dato0, Dato1, Listo,
    input  Concesion0, Concesion1, Selector, Salida, Valido,
           Hecho0, Hecho1, ErrorEspera
  );

  modport slave (
    input  Solicitud0, Solicitud1, Dato0, Dato1, Listo,
    output Concesion0, Concesion1, Selector, Salida, Valido,
           Hecho0, Hecho1, ErrorEspera
  );
endinterface

// File: rtl/arbitro_bus16_2x1.sv
// Two-requester round-robin arbiter for a shared 16-bit bus. A grant is held
// until the resource signals Listo, the owner drops its request, or the
// watchdog expires; each release re-arbitrates in the same edge so there is
// no idle bubble on a handoff.
module arbitro_bus16_2x1 #(
  parameter int ANCHO      = 16,
  parameter int MAX_ESPERA = 15,
  parameter int ANCHO_CONT = 4
) (
  input  logic                Reloj,
  input  logic                Reset,
  arbitro_bus16_2x1_if.slave  bus
);

  localparam logic [ANCHO_CONT-1:0] LIM = ANCHO_CONT'(MAX_ESPERA - 1);

  typedef enum logic [1:0] {LIBRE, CONC0, CONC1} estado_t;

  estado_t               estado, sig_estado;
  logic                  ultimo, sig_ultimo;
  logic [ANCHO_CONT-1:0] cont;
  logic                  conc0_q, conc1_q, sel_q;
  logic                  hecho0_q, hecho1_q, err_q;
  logic                  dueno, sol_dueno, fin, aborto, vence, libera;

  // Round-robin pick: a tie goes to the requester that was not served last.
  function automatic estado_t decidir(input logic s0, input logic s1,
                                      input logic ult);
    if (s0 && s1) return ult ? CONC0 : CONC1;
    else if (s0)  return CONC0;
    else if (s1)  return CONC1;
    else          return LIBRE;
  endfunction

  // Release conditions in priority order (completion, abort, watchdog) and
  // the resulting next grant.
  always_comb begin
    dueno      = (estado == CONC1);
    sol_dueno  = dueno ? bus.Solicitud1 : bus.Solicitud0;
    fin        = (estado != LIBRE) && bus.Listo;
    aborto     = (estado != LIBRE) && !bus.Listo && !sol_dueno;
    vence      = (estado != LIBRE) && !bus.Listo && sol_dueno && (cont == LIM);
    libera     = fin || aborto || vence;
    sig_ultimo = libera ? dueno : ultimo;
    sig_estado = estado;
    if (estado == LIBRE || libera)
      sig_estado = decidir(bus.Solicitud0, bus.Solicitud1, sig_ultimo);
  end

  // FSM state, watchdog counter and all registered outputs.
  always_ff @(posedge Reloj) begin
    if (Reset) begin
      estado   <= LIBRE;
      ultimo   <= 1'b1;
      cont     <= '0;
      conc0_q  <= 1'b0;
      conc1_q  <= 1'b0;
      sel_q    <= 1'b0;
      hecho0_q <= 1'b0;
      hecho1_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      estado   <= sig_estado;
      ultimo   <= sig_ultimo;
      conc0_q  <= (sig_estado == CONC0);
      conc1_q  <= (sig_estado == CONC1);
      // Selector keeps pointing at the last owner while idle.
      if (sig_estado != LIBRE) sel_q <= (sig_estado == CONC1);
      hecho0_q <= fin && !dueno;
      hecho1_q <= fin && dueno;
      err_q    <= vence;
      // Counter restarts on every grant, including a re-grant to the same owner.
      if (estado == LIBRE || libera) cont <= '0;
      else                           cont <= cont + 1'b1;
    end
  end

  assign bus.Concesion0  = conc0_q;
  assign bus.Concesion1  = conc1_q;
  assign bus.Selector    = sel_q;
  assign bus.Valido      = conc0_q | conc1_q;
  assign bus.Hecho0      = hecho0_q;
  assign bus.Hecho1      = hecho1_q;
  assign bus.ErrorEspera = err_q;
  assign bus.Salida      = ANCHO'(sel_q ? bus.Dato1 : bus.Dato0);

endmodule

// File: doc/arbitro_bus16_2x1.md
Name: arbitro_bus16_2x1

Overview:
Round-robin arbiter and sequencer that shares one 16-bit bus between two requesters, e.g. instruction fetch and data access to a single memory port. It drives the select line of the 2:1 16-bit bus multiplexer. It holds each grant until the shared resource signals completion, the requester aborts, or a watchdog expires. Each outcome is reported back with one-cycle status pulses.

Parameters:
ANCHO, 16, data width of each requester input and of Salida
MAX_ESPERA, 15, granted cycles without Listo before the watchdog fires (1..2^ANCHO_CONT-1)
ANCHO_CONT, 4, width of the watchdog counter

Ports:
Reloj  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Solicitud0  input  1  requester 0 request, level
Solicitud1  input  1  requester 1 request, level
Dato0  input  ANCHO  requester 0 bus word
Dato1  input  ANCHO  requester 1 bus word
Listo  input  1  shared resource completes the current transaction this cycle
Concesion0  output  1  grant to requester 0, registered
Concesion1  output  1  grant to requester 1, registered
Selector  output  1  mux select; 0 = Dato0, 1 = Dato1, registered
Salida  output  ANCHO  shared bus word; combinational, Dato0 when Selector=0 else Dato1
Valido  output  1  bus word valid to the resource; equals Concesion0|Concesion1
Hecho0  output  1  one-cycle pulse: requester 0 transaction completed
Hecho1  output  1  one-cycle pulse: requester 1 transaction completed
ErrorEspera  output  1  one-cycle pulse: watchdog released a grant

Behaviour:
- One clock (Reloj); reset is synchronous and active-high (Reset).
- Reset values: state LIBRE, Concesion0=Concesion1=0, Selector=0, Valido=0, Hecho0=Hecho1=0, ErrorEspera=0, counter=0, Ultimo=1. With Ultimo=1, requester 0 wins the first tie.
- States: LIBRE, CONC0, CONC1. Concesion_i=1 exactly when in CONC_i. Selector holds its last value while in LIBRE.
- Grant decision (function of Solicitud0, Solicitud1, Ultimo), used in LIBRE and at every release:
  - only one request: grant that requester;
  - both requests: grant the requester != Ultimo;
  - none: go to LIBRE.
- Latency: a request sampled at edge k gives Concesion/Selector/Valido high after edge k. There is no extra bubble.
- In CONC_i, evaluated each edge in this priority order:
  1. Reset.
  2. Listo=1: completion. Hecho_i=1 next cycle, Ultimo<=i, counter<=0, apply the grant decision with Ultimo=i.
     - This gives a direct handoff to the other requester if it is requesting.
     - If only i is requesting, i is re-granted.
  3. Solicitud_i=0: abort. Ultimo<=i, counter<=0, no Hecho, apply the grant decision.
  4. counter==MAX_ESPERA-1: watchdog. ErrorEspera=1 next cycle, Ultimo<=i, counter<=0, apply the grant decision.
  5. Otherwise: counter<=counter+1, stay in CONC_i.
- Listo and Solicitud_i=0 in the same cycle count as completion (Hecho pulses).
- Listo while in LIBRE is ignored.
- Hecho_i and ErrorEspera are registered, last exactly one cycle, and are mutually exclusive.
- Counter: ANCHO_CONT bits, unsigned, cleared on every grant change and on re-grant, never wraps. The watchdog fires on the MAX_ESPERA-th consecutive granted cycle without Listo.
- Reset mid-transaction: grant drops on the next cycle with no Hecho or ErrorEspera pulse. Ultimo returns to 1.

Test Plan:
- Reset, then Solicitud0=1 only, Listo=1 on the 3rd granted cycle -> Concesion0=1, Selector=0, Salida=Dato0 (0xA5A5) for 3 cycles; Hecho0=1 for 1 cycle; return to LIBRE.
- Both requests held continuously, Listo=1 every 2nd cycle -> grants alternate 0,1,0,1 with no idle cycle; Selector toggles; Hecho0/Hecho1 pulses alternate.
- Solicitud1=1, Listo held 0, MAX_ESPERA=15 -> Concesion1 high exactly 15 cycles; ErrorEspera pulses once; Ultimo=1, so a subsequent tie grants requester 0.
- Requester 0 granted; Solicitud0 drops on 2nd cycle while Solicitud1=1 -> Concesion1=1 on the next cycle; no Hecho0 and no ErrorEspera.
- Reset asserted while in CONC1 with counter=7 -> all outputs 0 the next cycle; on release with both requesting, requester 0 is granted first.
- Listo=1 while idle, and Listo coinciding with Solicitud0 dropping -> no effect while idle; Hecho0 pulses in the coincident case.
